placar_multijogador: RTL

//  Parametrised successor of the two-player win counter on the Nexys A7 board.
//  - Keeps a score per player from win pulses (as emitted by the BullsCows game).
//  - Ends the match when a player reaches WIN_TARGET and latches the champion.
//  - Drives a per-player thermometer LED bar; new_match restarts the match.

---
 rtl/placar_multijogador_if.sv | 36 +++
 rtl/placar_multijogador.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/placar_multijogador_if.sv
// ============================================================================
// Module   : placar_multijogador_if
// Brief    : Bus bundle for the multi-player scoreboard (win inputs, LED bar,
//            packed scores and match flags).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface placar_multijogador_if #(
    parameter int N_PLAYERS       = 2,
    parameter int LEDS_PER_PLAYER = 8,
    parameter int WIN_TARGET      = 3
);
    localparam int c_SW = $clog2(WIN_TARGET + 1);
    localparam int c_PW = $clog2(N_PLAYERS);

    logic [N_PLAYERS-1:0]                 win;
    logic                                 new_match;
    logic [N_PLAYERS*LEDS_PER_PLAYER-1:0] led;
    logic [N_PLAYERS*c_SW-1:0]            scores;
    logic                                 match_over;
    logic [c_PW-1:0]                      champion;
    logic                                 conflict;

    modport master (
        output win, new_match,
        input  led, scores, match_over, champion, conflict
    );

    modport slave (
        input  win, new_match,
        output led, scores, match_over, champion, conflict
    );
endinterface

`default_nettype wire

// File: rtl/placar_multijogador.sv
// ============================================================================
// Module   : placar_multijogador
// Brief    : N-player win counter with champion latch and thermometer LED bars.
//            Optional champion blink enabled by defining PLACAR_BLINK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module placar_multijogador #(
    parameter int N_PLAYERS       = 2,
    parameter int LEDS_PER_PLAYER = 8,
    parameter int WIN_TARGET      = 3,
    parameter int BLINK_DIV       = 25_000_000
) (
    input  wire logic             clock,
    input  wire logic             reset,
    placar_multijogador_if.slave  bus
);
    localparam int c_SW = $clog2(WIN_TARGET + 1);
    localparam int c_PW = $clog2(N_PLAYERS);
    localparam int c_LW = N_PLAYERS * LEDS_PER_PLAYER;

    if (N_PLAYERS < 2 || WIN_TARGET < 1 || WIN_TARGET > LEDS_PER_PLAYER || BLINK_DIV < 1) begin : g_param_check
        $error("placar_multijogador: illegal parameter combination");
    end

    typedef enum logic [0:0] {
        ST_PLAY = 1'b0,
        ST_OVER = 1'b1
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [N_PLAYERS-1:0]   r_win_q;
    logic [N_PLAYERS-1:0]   w_rise, w_grant;
    logic [c_SW-1:0]        r_score     [N_PLAYERS];
    logic [c_SW-1:0]        w_score_nxt [N_PLAYERS];
    logic [c_PW-1:0]        r_champion, w_champion_nxt;
    logic                   r_conflict, w_conflict_nxt;
    logic [c_LW-1:0]        r_led, w_led_nxt;

`ifdef PLACAR_BLINK_EN
    localparam int c_CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    logic [c_CW-1:0]        r_blink_cnt, w_blink_cnt_nxt;
    logic                   r_blink_on, w_blink_on_nxt;
`endif

    always_comb begin
        w_rise = bus.win & ~r_win_q;
        // Isolate the lowest-index rising bit: only that player is credited
        w_grant        = w_rise & (-w_rise);
        w_state_nxt    = r_state;
        w_champion_nxt = r_champion;
        w_conflict_nxt = 1'b0;
        for (int p = 0; p < N_PLAYERS; p++) begin
            w_score_nxt[p] = r_score[p];
        end

        if (bus.new_match) begin
            for (int p = 0; p < N_PLAYERS; p++) begin
                w_score_nxt[p] = '0;
            end
            w_champion_nxt = '0;
            w_state_nxt    = ST_PLAY;
        end else if (r_state == ST_PLAY) begin
            w_conflict_nxt = ($countones(w_rise) > 1);
            for (int p = 0; p < N_PLAYERS; p++) begin
                if (w_grant[p]) begin
                    w_score_nxt[p] = r_score[p] + c_SW'(1);
                    if (r_score[p] == c_SW'(WIN_TARGET - 1)) begin
                        w_state_nxt    = ST_OVER;
                        w_champion_nxt = c_PW'(p);
                    end
                end
            end
        end

`ifdef PLACAR_BLINK_EN
        // Counter restarts on OVER entry with the lit phase first
        w_blink_cnt_nxt = '0;
        w_blink_on_nxt  = 1'b0;
        if (w_state_nxt == ST_OVER) begin
            if (r_state != ST_OVER) begin
                w_blink_on_nxt = 1'b1;
            end else if (r_blink_cnt == c_CW'(BLINK_DIV - 1)) begin
                w_blink_on_nxt = ~r_blink_on;
            end else begin
                w_blink_cnt_nxt = r_blink_cnt + c_CW'(1);
                w_blink_on_nxt  = r_blink_on;
            end
        end
`endif

        w_led_nxt = '0;
        for (int p = 0; p < N_PLAYERS; p++) begin
            for (int i = 0; i < LEDS_PER_PLAYER; i++) begin
                w_led_nxt[p*LEDS_PER_PLAYER + i] = (i < int'(w_score_nxt[p]));
`ifdef PLACAR_BLINK_EN
                if (w_state_nxt == ST_OVER && w_champion_nxt == c_PW'(p)) begin
                    w_led_nxt[p*LEDS_PER_PLAYER + i] = w_blink_on_nxt;
                end
`endif
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_PLAY;
            r_win_q    <= '0;
            r_champion <= '0;
            r_conflict <= 1'b0;
            r_led      <= '0;
            for (int p = 0; p < N_PLAYERS; p++) begin
                r_score[p] <= '0;
            end
        end else begin
            r_state    <= w_state_nxt;
            r_win_q    <= bus.win;
            r_champion <= w_champion_nxt;
            r_conflict <= w_conflict_nxt;
            r_led      <= w_led_nxt;
            for (int p = 0; p < N_PLAYERS; p++) begin
                r_score[p] <= w_score_nxt[p];
            end
        end
    end

`ifdef PLACAR_BLINK_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b0;
        end else begin
            r_blink_cnt <= w_blink_cnt_nxt;
            r_blink_on  <= w_blink_on_nxt;
        end
    end
`endif

    for (genvar p = 0; p < N_PLAYERS; p++) begin : g_pack_scores
        assign bus.scores[p*c_SW +: c_SW] = r_score[p];
    end

    assign bus.led        = r_led;
    assign bus.match_over = (r_state == ST_OVER);
    assign bus.champion   = r_champion;
    assign bus.conflict   = r_conflict;

endmodule

`default_nettype wire
